// File: rtl/bus_rr_arbiter.sv
// Four-master round-robin bus arbiter with active-low handshakes, a bus-timeout
// watchdog and per-master masking of masters that timed out.
module bus_rr_arbiter #(
  parameter int TO_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  input  logic       s_as_,
  input  logic       m_rdy_,
  output logic [1:0] owner,
  output logic       busy,
  output logic       bus_err,
  output logic [1:0] err_owner
);

  localparam int CW = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYCLES - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state, state_nxt;
  logic [3:0]    req_low, avail;
  logic [3:0]    grnt_q, grnt_nxt;
  logic [3:0]    mask, mask_nxt;
  logic [1:0]    owner_nxt, err_owner_nxt;
  logic [1:0]    winner, cand;
  logic          found, stall, busy_nxt, bus_err_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  assign req_low = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign avail   = req_low & ~mask;
  assign stall   = ~s_as_ & m_rdy_;
  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_q;

  // Round-robin search starting just after the last owner; the last owner is
  // visited last so a lone requester can still be re-granted.
  always_comb begin
    winner = owner;
    found  = 1'b0;
    cand   = owner;
    for (int i = 1; i <= 4; i++) begin
      cand = owner + 2'(i);
      if (!found && avail[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grnt_nxt      = grnt_q;
    owner_nxt     = owner;
    err_owner_nxt = err_owner;
    bus_err_nxt   = 1'b0;
    cnt_nxt       = '0;
    mask_nxt      = mask & req_low;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = OWN;
          grnt_nxt  = ~(4'b0001 << winner);
          owner_nxt = winner;
        end
      end
      OWN: begin
        // Timeout beats a same-cycle release; the mask is only set if the
        // owner is still requesting, since a release already clears it.
        if (stall && cnt == CNT_LAST) begin
          state_nxt     = IDLE;
          grnt_nxt      = 4'hF;
          bus_err_nxt   = 1'b1;
          err_owner_nxt = owner;
          if (req_low[owner]) mask_nxt[owner] = 1'b1;
        end else if (!req_low[owner]) begin
          state_nxt = IDLE;
          grnt_nxt  = 4'hF;
        end else if (stall) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
    busy_nxt = ~&grnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      grnt_q    <= 4'hF;
      owner     <= 2'd3;
      busy      <= 1'b0;
      bus_err   <= 1'b0;
      err_owner <= 2'd0;
      cnt       <= '0;
      mask      <= 4'h0;
    end else begin
      state     <= state_nxt;
      grnt_q    <= grnt_nxt;
      owner     <= owner_nxt;
      busy      <= busy_nxt;
      bus_err   <= bus_err_nxt;
      err_owner <= err_owner_nxt;
      cnt       <= cnt_nxt;
      mask      <= mask_nxt;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: a rule-level model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_bus_rr_arbiter;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req_, m1_req_, m2_req_, m3_req_;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic       s_as_, m_rdy_;
  logic [1:0] owner, err_owner;
  logic       busy, bus_err;
  logic [3:0] grnt_vec;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign grnt_vec = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

  bus_rr_arbiter #(.TO_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req_(m0_req_), .m1_req_(m1_req_), .m2_req_(m2_req_), .m3_req_(m3_req_),
    .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
    .s_as_(s_as_), .m_rdy_(m_rdy_),
    .owner(owner), .busy(busy), .bus_err(bus_err), .err_owner(err_owner)
  );

  // Model: who holds the bus (-1 = nobody), who held it last, how many
  // consecutive stalled cycles the holder has seen, and who is banned.
  int       m_gnt, m_last, m_wait;
  bit       m_err;
  bit [1:0] m_err_owner;
  bit [3:0] m_masked;
  bit       model_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkState(input string name, input logic [3:0] g, input logic [1:0] o,
                            input logic b, input logic e);
    checkOutput({name, "_grnt"}, {4'b0, grnt_vec}, {4'b0, g});
    checkOutput({name, "_owner"}, {6'b0, owner}, {6'b0, o});
    checkOutput({name, "_busy"}, {7'b0, busy}, {7'b0, b});
    checkOutput({name, "_err"}, {7'b0, bus_err}, {7'b0, e});
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] rq, input logic as_, input logic rdy_);
    reset = rst;
    {m3_req_, m2_req_, m1_req_, m0_req_} = rq;
    s_as_  = as_;
    m_rdy_ = rdy_;
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    logic [3:0] rq;
    logic [3:0] old_mask;
    int c;
    rq = {m3_req_, m2_req_, m1_req_, m0_req_};
    if (!reset) begin
      m_gnt = -1; m_last = 3; m_wait = 0;
      m_err = 1'b0; m_err_owner = 2'd0; m_masked = 4'h0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      old_mask = m_masked;
      m_masked = m_masked & ~rq;
      m_err = 1'b0;
      if (m_gnt < 0) begin
        m_wait = 0;
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (m_gnt < 0 && rq[c] == 1'b0 && old_mask[c] == 1'b0) begin
            m_gnt = c;
            m_last = c;
          end
        end
      end else if (!s_as_ && m_rdy_ && m_wait + 1 == TO) begin
        m_err = 1'b1;
        m_err_owner = 2'(m_gnt);
        if (rq[m_gnt] == 1'b0) m_masked[m_gnt] = 1'b1;
        m_gnt = -1;
        m_wait = 0;
      end else if (rq[m_gnt]) begin
        m_gnt = -1;
        m_wait = 0;
      end else begin
        m_wait = (!s_as_ && m_rdy_) ? m_wait + 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_g;
    if (model_valid) begin
      exp_g = 4'hF;
      if (m_gnt >= 0) exp_g[m_gnt] = 1'b0;
      checkOutput("cmp_grnt", {4'b0, grnt_vec}, {4'b0, exp_g});
      checkOutput("cmp_owner", {6'b0, owner}, 8'(m_last));
      checkOutput("cmp_busy", {7'b0, busy}, {7'b0, (m_gnt >= 0)});
      checkOutput("cmp_bus_err", {7'b0, bus_err}, {7'b0, m_err});
      checkOutput("cmp_err_owner", {6'b0, err_owner}, {6'b0, m_err_owner});
    end
  end

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;

    // Reset with m1/m2 requesting, then first arbitration and handover
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1001, 1'b1, 1'b1);
    checkState("rst", 4'hF, 2'd3, 1'b0, 1'b0);
    checkOutput("rst_err_owner", {6'b0, err_owner}, 8'd0);
    applyStimulus(1'b1, 4'b1001, 1'b1, 1'b1);
    checkState("first_m1", 4'b1101, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1011, 1'b1, 1'b1);
    checkState("gap_m1", 4'hF, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1011, 1'b1, 1'b1);
    checkState("then_m2", 4'b1011, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
    checkState("gap_m2", 4'hF, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1011, 1'b1, 1'b1);
    checkState("regrant_m2", 4'b1011, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);

    // All four request continuously, each releasing after 3 granted cycles
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'hF;
      exp_g[order[i]] = 1'b0;
      checkState("rr_grant", exp_g, 2'(order[i]), 1'b1, 1'b0);
      applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
      applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
      applyStimulus(1'b1, 4'b0001 << order[i], 1'b1, 1'b1);
      checkState("rr_gap", 4'hF, 2'(order[i]), 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
    end
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);

    // Timeout of m2 with the request held, then m2 stays masked
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1011, 1'b1, 1'b1);
    checkState("to_grant", 4'b1011, 2'd2, 1'b1, 1'b0);
    for (int w = 1; w <= 4; w++) begin
      applyStimulus(1'b1, 4'b1011, 1'b0, 1'b1);
      if (w < 4) checkState("to_wait", 4'b1011, 2'd2, 1'b1, 1'b0);
    end
    checkState("to_err", 4'hF, 2'd2, 1'b0, 1'b1);
    checkOutput("to_err_owner", {6'b0, err_owner}, 8'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'b1011, 1'b1, 1'b1);
      checkState("to_masked", 4'hF, 2'd2, 1'b0, 1'b0);
    end
    checkOutput("to_err_owner_hold", {6'b0, err_owner}, 8'd2);

    // Masked m2 releases once, then is granted again
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
    checkState("unmask_idle", 4'hF, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1011, 1'b1, 1'b1);
    checkState("unmask_grant", 4'b1011, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);

    // Ready on the 4th stalled cycle wins over the timeout
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1011, 1'b1, 1'b1);
    for (int w = 0; w < 3; w++) applyStimulus(1'b1, 4'b1011, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b1011, 1'b0, 1'b0);
    checkState("rdy_wins", 4'b1011, 2'd2, 1'b1, 1'b0);
    for (int w = 0; w < 3; w++) applyStimulus(1'b1, 4'b1011, 1'b0, 1'b1);
    checkState("rdy_restart", 4'b1011, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
    checkState("rdy_release", 4'hF, 2'd2, 1'b0, 1'b0);

    // Release in the timeout cycle: error reported but no mask
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1011, 1'b1, 1'b1);
    for (int w = 0; w < 3; w++) applyStimulus(1'b1, 4'b1011, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1);
    checkState("rel_to_err", 4'hF, 2'd2, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b1011, 1'b1, 1'b1);
    checkState("rel_to_nomask", 4'b1011, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);

    // Reset mid-ownership with a pending access
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
    checkOutput("rst2_err_owner", {6'b0, err_owner}, 8'd0);
    applyStimulus(1'b1, 4'b1110, 1'b1, 1'b1);
    checkState("mid_grant", 4'b1110, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1110, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b1110, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b1110, 1'b0, 1'b1);
    checkState("mid_reset", 4'hF, 2'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
    checkState("post_reset", 4'b1110, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
